// File: rtl/mbist_checkerboard_ctrl.sv
// Checkerboard MBIST controller: sequences the pattern counter, gates it onto the SRAM
// port and checks read data through a READ_LAT-deep compare pipeline.
module mbist_checkerboard_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 4,
    parameter int READ_LAT   = 1,
    parameter int FAIL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     gen_addr,
    input  logic [DATA_W-1:0]     gen_data,
    input  logic                  gen_we,
    input  logic                  gen_cout,
    output logic                  gen_cen,
    output logic                  gen_rst,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic [DATA_W-1:0]     first_fail_data
);

    localparam int DCW = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [DCW-1:0]                 drain_q, drain_d;
    logic [READ_LAT-1:0]            vld_q;
    logic [READ_LAT-1:0][ADDR_W-1:0] paddr_q;
    logic [READ_LAT-1:0][DATA_W-1:0] pexp_q;
    logic [FAIL_CNT_W-1:0]          fcnt_q, fcnt_d;
    logic [ADDR_W-1:0]              ffa_q, ffa_d;
    logic [DATA_W-1:0]              ffd_q, ffd_d;
    logic                           seen_q, seen_d;

    logic run, rd_push, flush, miscmp;

    assign run      = (state_q == S_RUN);
    assign gen_cen  = run & ~gen_cout;
    assign mem_en   = run & ~gen_cout;
    assign mem_we   = gen_we & mem_en;
    assign mem_addr  = run ? gen_addr : '0;
    assign mem_wdata = run ? gen_data : '0;
    assign gen_rst  = rst | (state_q == S_CLEAR);
    assign busy     = (state_q == S_CLEAR) | run | (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign pass     = done & (fcnt_q == '0);

    assign fail_count      = fcnt_q;
    assign first_fail_addr = ffa_q;
    assign first_fail_data = ffd_q;

    assign rd_push = mem_en & ~mem_we;
    // Anything that leaves RUN/DRAIN (abort, completion, new run) empties the pipe.
    assign flush   = !(state_d == S_RUN || state_d == S_DRAIN);
    assign miscmp  = vld_q[READ_LAT-1] && (mem_rdata != pexp_q[READ_LAT-1]);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gen_cout) begin
                    state_d = S_DRAIN;
                    drain_d = DCW'(READ_LAT - 1);
                end
            end
            S_DRAIN: begin
                if (abort)                state_d = S_IDLE;
                else if (drain_q == '0)   state_d = S_DONE;
                else                      drain_d = drain_q - DCW'(1);
            end
            S_DONE: begin
                if (abort)      state_d = S_IDLE;
                else if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        ffa_d  = ffa_q;
        ffd_d  = ffd_q;
        seen_d = seen_q;
        if (state_d == S_CLEAR && state_q != S_CLEAR) begin
            fcnt_d = '0;
            ffa_d  = '0;
            ffd_d  = '0;
            seen_d = 1'b0;
        end else if (miscmp) begin
            if (fcnt_q != '1) fcnt_d = fcnt_q + FAIL_CNT_W'(1);
            if (!seen_q) begin
                ffa_d  = paddr_q[READ_LAT-1];
                ffd_d  = mem_rdata;
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            fcnt_q  <= '0;
            ffa_q   <= '0;
            ffd_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            fcnt_q  <= fcnt_d;
            ffa_q   <= ffa_d;
            ffd_q   <= ffd_d;
            seen_q  <= seen_d;
        end
    end

    // Stage 0 holds the access issued last cycle; stage READ_LAT-1 lines up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            paddr_q <= '0;
            pexp_q  <= '0;
        end else if (flush) begin
            vld_q   <= '0;
            paddr_q <= '0;
            pexp_q  <= '0;
        end else begin
            vld_q[0]   <= rd_push;
            paddr_q[0] <= gen_addr;
            pexp_q[0]  <= gen_data;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mbist_checkerboard_ctrl.sv
// Directed bench: two controllers (READ_LAT 1 and 3), each with a pattern counter and
// SRAM model carrying selectable read faults.
module tb_mbist_checkerboard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int fault_mode = 0;  // 0 good, 1 bit0 stuck-at-0 at addr 0x05, 2 reads all zero

    logic [1:0] start_a = '0;
    logic [1:0] abort_a = '0;
    logic [1:0] gen_cen_a, gen_rst_a, mem_en_a, busy_a, done_a, pass_a;
    logic [7:0] fc_a   [2];
    logic [7:0] ffa_a  [2];
    logic [3:0] ffd_a  [2];
    logic [7:0] maddr_a[2];

    function automatic logic [3:0] rd_fault(input logic [7:0] a, input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (fault_mode == 1 && a == 8'h05) r[0] = 1'b0;
        if (fault_mode == 2) r = 4'h0;
        return r;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int RL = (k == 0) ? 1 : 3;
        logic [10:0] cnt_q;
        logic [3:0]  mem [256];
        logic [3:0]  rd_dly [RL];
        logic [7:0]  gen_addr, mem_addr;
        logic [3:0]  gen_data, mem_wdata, mem_rdata;
        logic        gen_we, gen_cout, mem_we;

        // Counter model: phases write A, read A, write ~A, read ~A over 256 words each.
        assign gen_addr  = cnt_q[7:0];
        assign gen_we    = ~cnt_q[8];
        assign gen_data  = (cnt_q[0] ^ cnt_q[9]) ? 4'b0101 : 4'b1010;
        assign gen_cout  = cnt_q[10];
        assign mem_rdata = rd_dly[RL-1];
        assign maddr_a[k] = mem_addr;

        always @(posedge clk) begin
            if (gen_rst_a[k]) cnt_q <= '0;
            else if (gen_cen_a[k] && !gen_cout) cnt_q <= cnt_q + 11'd1;
            if (mem_en_a[k] && mem_we) mem[mem_addr] <= mem_wdata;
            rd_dly[0] <= (mem_en_a[k] && !mem_we) ? rd_fault(mem_addr, mem[mem_addr]) : 4'h0;
            for (int i = 1; i < RL; i++) rd_dly[i] <= rd_dly[i-1];
        end

        mbist_checkerboard_ctrl #(.READ_LAT(RL)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start_a[k]),
            .abort           (abort_a[k]),
            .gen_addr        (gen_addr),
            .gen_data        (gen_data),
            .gen_we          (gen_we),
            .gen_cout        (gen_cout),
            .gen_cen         (gen_cen_a[k]),
            .gen_rst         (gen_rst_a[k]),
            .mem_en          (mem_en_a[k]),
            .mem_we          (mem_we),
            .mem_addr        (mem_addr),
            .mem_wdata       (mem_wdata),
            .mem_rdata       (mem_rdata),
            .busy            (busy_a[k]),
            .done            (done_a[k]),
            .pass            (pass_a[k]),
            .fail_count      (fc_a[k]),
            .first_fail_addr (ffa_a[k]),
            .first_fail_data (ffd_a[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start, check the done boundary, then the result registers.
    task automatic do_run(input int k, input int lat, input logic [7:0] efc,
                          input logic [7:0] effa, input logic [3:0] effd, input logic epass);
        start_a[k] = 1'b1;
        tick(1);
        start_a[k] = 1'b0;
        check("clear_gen_rst", gen_rst_a[k], 1'b1);
        tick(1025 + lat);
        check("done_early", done_a[k], 1'b0);
        tick(1);
        check("done_on_time", done_a[k], 1'b1);
        check("busy_in_done", busy_a[k], 1'b0);
        check("fail_count", fc_a[k], efc);
        check("first_fail_addr", ffa_a[k], effa);
        check("first_fail_data", ffd_a[k], effd);
        check("pass", pass_a[k], epass);
    endtask

    initial begin
        tick(2);
        check("rst_gen_rst", gen_rst_a[0], 1'b1);
        check("rst_busy", busy_a[0], 1'b0);
        check("rst_mem_en", mem_en_a[0], 1'b0);
        rst = 1'b0;
        tick(1);
        check("idle_done", done_a[0], 1'b0);
        check("idle_pass", pass_a[0], 1'b0);
        check("idle_fc", fc_a[0], 8'h00);
        check("idle_gen_rst", gen_rst_a[0], 1'b0);

        // start and abort together: abort wins
        start_a[0] = 1'b1; abort_a[0] = 1'b1;
        tick(1);
        start_a[0] = 1'b0; abort_a[0] = 1'b0;
        check("start_abort_busy", busy_a[0], 1'b0);

        fault_mode = 0;
        do_run(0, 1, 8'h00, 8'h00, 4'h0, 1'b1);
        tick(5);
        check("done_held", done_a[0], 1'b1);

        fault_mode = 1;
        do_run(0, 1, 8'h01, 8'h05, 4'b0100, 1'b0);

        fault_mode = 2;
        do_run(0, 1, 8'hFF, 8'h00, 4'h0, 1'b0);

        // abort mid-run keeps partial results but drops done/pass
        start_a[0] = 1'b1;
        tick(1);
        start_a[0] = 1'b0;
        tick(400);
        check("pre_abort_mem_en", mem_en_a[0], 1'b1);
        abort_a[0] = 1'b1;
        tick(1);
        abort_a[0] = 1'b0;
        check("abort_busy", busy_a[0], 1'b0);
        check("abort_mem_en", mem_en_a[0], 1'b0);
        check("abort_done", done_a[0], 1'b0);
        check("abort_pass", pass_a[0], 1'b0);
        check("abort_fc_partial", (fc_a[0] != 8'h00), 1'b1);
        check("abort_ffa_partial", ffa_a[0], 8'h00);
        check("abort_mem_addr", maddr_a[0], 8'h00);

        fault_mode = 0;
        do_run(0, 1, 8'h00, 8'h00, 4'h0, 1'b1);

        // start held in DONE re-arms; abort in CLEAR returns to idle
        start_a[0] = 1'b1;
        tick(1);
        start_a[0] = 1'b0;
        check("rearm_busy", busy_a[0], 1'b1);
        check("rearm_done", done_a[0], 1'b0);
        abort_a[0] = 1'b1;
        tick(1);
        abort_a[0] = 1'b0;
        check("abort_clear_busy", busy_a[0], 1'b0);

        do_run(1, 3, 8'h00, 8'h00, 4'h0, 1'b1);
        fault_mode = 1;
        do_run(1, 3, 8'h01, 8'h05, 4'b0100, 1'b0);
        fault_mode = 0;

        // start during RUN is ignored; async rst mid-run forces idle
        start_a[0] = 1'b1;
        tick(1);
        start_a[0] = 1'b0;
        tick(100);
        start_a[0] = 1'b1;
        tick(1);
        start_a[0] = 1'b0;
        check("start_in_run_gen_rst", gen_rst_a[0], 1'b0);
        check("start_in_run_mem_en", mem_en_a[0], 1'b1);
        tick(197);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy_a[0], 1'b0);
        check("rst_mid_mem_en", mem_en_a[0], 1'b0);
        check("rst_mid_gen_cen", gen_cen_a[0], 1'b0);
        check("rst_mid_gen_rst", gen_rst_a[0], 1'b1);
        check("rst_mid_done", done_a[0], 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);
        do_run(0, 1, 8'h00, 8'h00, 4'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
